// File: rtl/gpio_pkg.sv
// Shared constants for the general-purpose input block: register offsets,
// debounce counter width and the byte-enable expansion helper.
package gpio_pkg;

    localparam int unsigned CntWidth = 16;
    localparam int unsigned MaxGpi   = 16;

    localparam logic [9:0] OffVal      = 10'h000;
    localparam logic [9:0] OffRaw      = 10'h004;
    localparam logic [9:0] OffRise     = 10'h008;
    localparam logic [9:0] OffFall     = 10'h00C;
    localparam logic [9:0] OffIntEn    = 10'h010;
    localparam logic [9:0] OffDebounce = 10'h014;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// One input bit: two-flop synchronizer, saturating stability counter and
// debounced level, with single-cycle rise/fall pulses on the edge deb changes.
module gpio_in_debounce
    import gpio_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                gp_i,
    input  logic [CntWidth-1:0] debounce_i,
    output logic                sync_o,
    output logic                deb_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic                sync1_r;
    logic                sync2_r;
    logic                deb_r;
    logic [CntWidth-1:0] cnt_r;
    logic [CntWidth:0]   cnt_inc_s;
    logic [CntWidth:0]   thresh_s;
    logic                differ_s;
    logic                fire_s;

    // Threshold compare; a programmed value of zero acts like one.
    always_comb begin
        differ_s  = sync2_r ^ deb_r;
        cnt_inc_s = {1'b0, cnt_r} + (CntWidth+1)'(1);
        if (debounce_i == '0) begin
            thresh_s = (CntWidth+1)'(1);
        end else begin
            thresh_s = {1'b0, debounce_i};
        end
        fire_s = differ_s && (cnt_inc_s >= thresh_s);
    end

    // Metastability filter for the asynchronous pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= gp_i;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter and debounced level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_r <= 1'b0;
            cnt_r <= '0;
        end else if (fire_s) begin
            deb_r <= sync2_r;
            cnt_r <= '0;
        end else if (differ_s) begin
            cnt_r <= cnt_inc_s[CntWidth] ? '1 : cnt_inc_s[CntWidth-1:0];
        end else begin
            cnt_r <= '0;
        end
    end

    assign sync_o = sync2_r;
    assign deb_o  = deb_r;
    assign rise_o = fire_s & sync2_r;
    assign fall_o = fire_s & ~sync2_r;

endmodule

// File: rtl/gpio_in.sv
// Debounced general-purpose input block with edge capture, W1C event
// registers and a level interrupt, accessed over a simple request bus.
module gpio_in
    import gpio_pkg::*;
#(
    parameter int unsigned GpiWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    input  logic [GpiWidth-1:0] gp_i,
    output logic                irq_o
);

    localparam logic [MaxGpi-1:0] GpiMask   = MaxGpi'((32'd1 << GpiWidth) - 32'd1);
    localparam logic [31:0]       IntEnMask = {GpiMask, GpiMask};

    logic [MaxGpi-1:0]   sync_s, deb_s, rise_evt_s, fall_evt_s;
    logic [MaxGpi-1:0]   rise_r, fall_r, rise_clr_s, fall_clr_s;
    logic [31:0]         int_en_r;
    logic [CntWidth-1:0] debounce_r;
    logic                rvalid_r;
    logic [31:0]         rdata_r;
    logic [9:0]          addr_s;
    logic [31:0]         wmask_s, wbits_s, rd_val_s;
    logic                int_en_wr_s, deb_wr_s;
    logic                unused_s;

    assign unused_s = ^device_addr_i[31:10];

    for (genvar i = 0; i < MaxGpi; i++) begin : g_bit
        if (i < GpiWidth) begin : g_used
            gpio_in_debounce u_debounce (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .gp_i       (gp_i[i]),
                .debounce_i (debounce_r),
                .sync_o     (sync_s[i]),
                .deb_o      (deb_s[i]),
                .rise_o     (rise_evt_s[i]),
                .fall_o     (fall_evt_s[i])
            );
        end else begin : g_unused
            assign sync_s[i]     = 1'b0;
            assign deb_s[i]      = 1'b0;
            assign rise_evt_s[i] = 1'b0;
            assign fall_evt_s[i] = 1'b0;
        end
    end

    // Write decode with per-byte masking.
    always_comb begin
        addr_s      = device_addr_i[9:0];
        wmask_s     = be_mask(device_be_i);
        wbits_s     = device_wdata_i & wmask_s;
        rise_clr_s  = '0;
        fall_clr_s  = '0;
        int_en_wr_s = 1'b0;
        deb_wr_s    = 1'b0;
        if (device_req_i && device_we_i) begin
            case (addr_s)
                OffRise:     rise_clr_s  = wbits_s[15:0];
                OffFall:     fall_clr_s  = wbits_s[15:0];
                OffIntEn:    int_en_wr_s = 1'b1;
                OffDebounce: deb_wr_s    = 1'b1;
                default:     int_en_wr_s = 1'b0;
            endcase
        end else begin
            deb_wr_s = 1'b0;
        end
    end

    // Read mux; unmapped offsets read zero.
    always_comb begin
        case (addr_s)
            OffVal:      rd_val_s = {16'h0000, deb_s};
            OffRaw:      rd_val_s = {16'h0000, sync_s};
            OffRise:     rd_val_s = {16'h0000, rise_r};
            OffFall:     rd_val_s = {16'h0000, fall_r};
            OffIntEn:    rd_val_s = int_en_r;
            OffDebounce: rd_val_s = {16'h0000, debounce_r};
            default:     rd_val_s = 32'h0000_0000;
        endcase
    end

    // Event capture; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            rise_r <= ((rise_r & ~rise_clr_s) | rise_evt_s) & GpiMask;
            fall_r <= ((fall_r & ~fall_clr_s) | fall_evt_s) & GpiMask;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_en_r   <= '0;
            debounce_r <= '0;
        end else begin
            if (int_en_wr_s) begin
                int_en_r <= ((int_en_r & ~wmask_s) | wbits_s) & IntEnMask;
            end
            if (deb_wr_s) begin
                debounce_r <= (debounce_r & ~wmask_s[15:0]) | wbits_s[15:0];
            end
        end
    end

    // Bus response: one cycle after every request, zero data for writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else begin
            rvalid_r <= device_req_i;
            if (device_req_i && !device_we_i) begin
                rdata_r <= rd_val_s;
            end else if (device_req_i) begin
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign device_rvalid_o = rvalid_r;
    assign device_rdata_o  = rdata_r;
    assign irq_o = |((rise_r & int_en_r[15:0]) | (fall_r & int_en_r[31:16]));

endmodule

// File: tb/tb_gpio_in.sv
// Directed self-checking bench for gpio_in: reset, debounce latency, glitch
// rejection, interrupt, W1C race, byte enables and mid-operation reset.
module tb_gpio_in;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        device_req_i = 1'b0;
    logic [31:0] device_addr_i = 32'h0;
    logic        device_we_i = 1'b0;
    logic [3:0]  device_be_i = 4'h0;
    logic [31:0] device_wdata_i = 32'h0;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;
    logic [15:0] gp_i = 16'h0000;
    logic        irq_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [15:0] val_hist [0:31];
    logic [31:0] rd;
    logic        rv;
    logic [31:0] wr_rdata;
    logic        wr_rvalid;

    localparam logic [31:0] A_VAL = 32'h00, A_RAW = 32'h04, A_RISE = 32'h08;
    localparam logic [31:0] A_FALL = 32'h0C, A_INTEN = 32'h10, A_DEB = 32'h14;

    gpio_in #(.GpiWidth(16)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .device_req_i    (device_req_i),
        .device_addr_i   (device_addr_i),
        .device_we_i     (device_we_i),
        .device_be_i     (device_be_i),
        .device_wdata_i  (device_wdata_i),
        .device_rvalid_o (device_rvalid_o),
        .device_rdata_o  (device_rdata_o),
        .gp_i            (gp_i),
        .irq_o           (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        device_req_i = 1'b1; device_we_i = 1'b1; device_addr_i = a;
        device_wdata_i = d; device_be_i = be;
        @(negedge clk_i);
        wr_rvalid = device_rvalid_o; wr_rdata = device_rdata_o;
        device_req_i = 1'b0; device_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        device_req_i = 1'b1; device_we_i = 1'b0; device_addr_i = a;
        @(negedge clk_i);
        d = device_rdata_o; v = device_rvalid_o;
        device_req_i = 1'b0;
    endtask

    // val_hist[k] holds deb as it stood after the (k-1)th rising edge.
    task automatic poll_val(input int n);
        device_req_i = 1'b1; device_we_i = 1'b0; device_addr_i = A_VAL;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_i);
            val_hist[k] = device_rdata_o[15:0];
        end
        device_req_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_i);
        vec_cnt++;
        if ({device_rvalid_o, device_rdata_o, irq_o} !== 34'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: rvalid=%0b rdata=%h irq=%0b, want all 0",
                     device_rvalid_o, device_rdata_o, irq_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        gp_i[0] = 1'b1;
        poll_val(6);
        vec_cnt++;
        if (val_hist[3] !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_val_early: VAL=%h, want 0000", val_hist[3]);
        end
        vec_cnt++;
        if (val_hist[4] !== 16'h0001) begin
            err_cnt++;
            $display("FAIL reset_val_3cyc: VAL=%h, want 0001", val_hist[4]);
        end
        bus_read(A_RISE, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0001 || rv !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_rise: RISE=%h rvalid=%0b, want 00000001/1", rd, rv);
        end
        vec_cnt++;
        if (irq_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_irq: irq=%0b, want 0", irq_o);
        end
    endtask

    task automatic test_glitch;
        bus_write(A_DEB, 32'd10, 4'hF);
        bus_write(A_RISE, 32'h0000_FFFF, 4'hF);
        gp_i[3] = 1'b1;
        repeat (5) @(negedge clk_i);
        gp_i[3] = 1'b0;
        repeat (12) @(negedge clk_i);
        bus_read(A_VAL, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0001) begin
            err_cnt++;
            $display("FAIL glitch_val: VAL=%h, want 00000001", rd);
        end
        bus_read(A_RISE, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0000) begin
            err_cnt++;
            $display("FAIL glitch_rise: RISE=%h, want 00000000", rd);
        end
        gp_i[3] = 1'b1;
        poll_val(16);
        vec_cnt++;
        if (val_hist[12][3] !== 1'b0 || val_hist[13][3] !== 1'b1) begin
            err_cnt++;
            $display("FAIL hold_latency: VAL@11=%h VAL@12=%h, want bit3 0 then 1",
                     val_hist[12], val_hist[13]);
        end
        bus_read(A_RISE, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0008) begin
            err_cnt++;
            $display("FAIL hold_rise: RISE=%h, want 00000008", rd);
        end
    endtask

    task automatic test_irq;
        bus_write(A_RISE, 32'h0000_FFFF, 4'hF);
        bus_write(A_INTEN, 32'h0004_0000, 4'hF);
        gp_i[2] = 1'b1;
        repeat (15) @(negedge clk_i);
        vec_cnt++;
        if (irq_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL irq_rise_masked: irq=%0b, want 0", irq_o);
        end
        gp_i[2] = 1'b0;
        repeat (15) @(negedge clk_i);
        vec_cnt++;
        if (irq_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL irq_fall: irq=%0b, want 1", irq_o);
        end
        bus_read(A_FALL, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0004) begin
            err_cnt++;
            $display("FAIL irq_fall_reg: FALL=%h, want 00000004", rd);
        end
        bus_write(A_FALL, 32'h0000_0004, 4'hF);
        vec_cnt++;
        if (irq_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL irq_clear: irq=%0b, want 0", irq_o);
        end
        bus_read(A_FALL, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0000) begin
            err_cnt++;
            $display("FAIL irq_fall_cleared: FALL=%h, want 00000000", rd);
        end
    endtask

    task automatic test_w1c_race;
        bus_write(A_DEB, 32'd0, 4'hF);
        gp_i[0] = 1'b0;
        repeat (5) @(negedge clk_i);
        bus_write(A_RISE, 32'h0000_FFFF, 4'hF);
        gp_i[0] = 1'b1;
        repeat (2) @(negedge clk_i);
        // Third rising edge carries both the clear and the new deb edge.
        bus_write(A_RISE, 32'h0000_0001, 4'hF);
        bus_read(A_RISE, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0001) begin
            err_cnt++;
            $display("FAIL w1c_race: RISE=%h, want 00000001", rd);
        end
        bus_write(A_RISE, 32'h0000_0001, 4'hF);
        bus_read(A_RISE, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0000) begin
            err_cnt++;
            $display("FAIL w1c_clear: RISE=%h, want 00000000", rd);
        end
    endtask

    task automatic test_bus;
        bus_write(A_INTEN, 32'hFFFF_FFFF, 4'h4);
        vec_cnt++;
        if (wr_rvalid !== 1'b1 || wr_rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL write_resp: rvalid=%0b rdata=%h, want 1/00000000", wr_rvalid, wr_rdata);
        end
        bus_read(A_INTEN, rd, rv);
        vec_cnt++;
        if (rd !== 32'h00FF_0000) begin
            err_cnt++;
            $display("FAIL byte_enable: INT_EN=%h, want 00ff0000", rd);
        end
        bus_read(32'h20, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0 || rv !== 1'b1) begin
            err_cnt++;
            $display("FAIL unmapped: rdata=%h rvalid=%0b, want 00000000/1", rd, rv);
        end
        @(negedge clk_i);
        vec_cnt++;
        if (device_rvalid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL rvalid_idle: rvalid=%0b, want 0", device_rvalid_o);
        end
        bus_write(A_VAL, 32'h0000_FFFF, 4'hF);
        bus_read(A_VAL, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0009) begin
            err_cnt++;
            $display("FAIL ro_write: VAL=%h, want 00000009", rd);
        end
        bus_read(A_RAW, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0009) begin
            err_cnt++;
            $display("FAIL raw: RAW=%h, want 00000009", rd);
        end
        bus_write(A_DEB, 32'h0000_1234, 4'h1);
        bus_read(A_DEB, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0000_0034) begin
            err_cnt++;
            $display("FAIL debounce_be: DEBOUNCE=%h, want 00000034", rd);
        end
    endtask

    task automatic test_mid_reset;
        bus_write(A_DEB, 32'd10, 4'hF);
        gp_i[5] = 1'b1;
        repeat (6) @(negedge clk_i);
        rst_ni = 1'b0;
        gp_i = 16'h0000;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        bus_read(A_VAL, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0) begin
            err_cnt++;
            $display("FAIL midrst_val: VAL=%h, want 00000000", rd);
        end
        bus_read(A_RISE, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0) begin
            err_cnt++;
            $display("FAIL midrst_rise: RISE=%h, want 00000000", rd);
        end
        bus_read(A_FALL, rd, rv);
        vec_cnt++;
        if (rd !== 32'h0 || irq_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_fall: FALL=%h irq=%0b, want 00000000/0", rd, irq_o);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_irq();
        test_w1c_race();
        test_bus();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
